// File: rtl/ram_256x8.sv
// 256 x 8 byte-addressable data memory with big-endian byte/half/word/dword
// accesses over a 64-bit bus; multi-byte accesses wrap modulo 256.
module ram_256x8 (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] DataIn,
  output logic [63:0] DataOut,
  input  logic        ReadWrite,
  input  logic [7:0]  Address,
  output logic        MOV,
  input  logic        Enable,
  input  logic [1:0]  Type
);

  logic [7:0]  mem [0:255];

  logic [63:0] data_out_q, data_out_d;
  logic        mov_q, mov_d;

  logic [3:0]  nbytes;
  logic [5:0]  shamt;
  logic [63:0] wr_word;
  logic [63:0] rd_word;
  logic [7:0]  lane_addr [0:7];
  logic [7:0]  lane_data [0:7];
  logic [7:0]  lane_we;

  // Data is handled left-justified: lane k is the byte at Address+k and sits
  // in bits [63-8k -: 8]; shifting by shamt converts to/from right-justified.
  always_comb begin
    case (Type)
      2'b00:   begin nbytes = 4'd1; shamt = 6'd56; end
      2'b01:   begin nbytes = 4'd2; shamt = 6'd48; end
      2'b10:   begin nbytes = 4'd4; shamt = 6'd32; end
      default: begin nbytes = 4'd8; shamt = 6'd0;  end
    endcase

    wr_word = DataIn << shamt;
    rd_word = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      lane_addr[k]        = Address + 8'(k);
      lane_data[k]        = wr_word[63 - 8*k -: 8];
      lane_we[k]          = Enable && !ReadWrite && !reset && (4'(k) < nbytes);
      rd_word[63 - 8*k -: 8] = mem[lane_addr[k]];
    end

    data_out_d = data_out_q;
    if (Enable && ReadWrite)
      data_out_d = rd_word >> shamt;
    mov_d = Enable;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      mov_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      mov_q      <= mov_d;
    end
    for (int unsigned k = 0; k < 8; k++) begin
      if (lane_we[k])
        mem[lane_addr[k]] <= lane_data[k];
    end
  end

  assign DataOut = data_out_q;
  assign MOV     = mov_q;

endmodule

// File: tb/tb_ram_256x8.sv
// Self-checking bench for ram_256x8: directed scenarios plus random accesses
// compared against a byte-array reference model.
module tb_ram_256x8;

  logic        clk;
  logic        reset;
  logic [63:0] DataIn;
  logic [63:0] DataOut;
  logic        ReadWrite;
  logic [7:0]  Address;
  logic        MOV;
  logic        Enable;
  logic [1:0]  Type;

  ram_256x8 dut (
    .clk       (clk),
    .reset     (reset),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .ReadWrite (ReadWrite),
    .Address   (Address),
    .MOV       (MOV),
    .Enable    (Enable),
    .Type      (Type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0]  ref_mem [0:255];
  logic [63:0] ref_out;
  logic        ref_mov;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: N = 2**Type bytes, byte k at (addr+k) mod 256, byte 0 most significant.
  task automatic model_step(input logic rst, input logic en, input logic rw,
                            input logic [7:0] addr, input logic [1:0] ty,
                            input logic [63:0] din);
    int unsigned n;
    logic [63:0] v;
    n = 1 << ty;
    if (rst) begin
      ref_out = 64'h0;
      ref_mov = 1'b0;
    end else if (en) begin
      ref_mov = 1'b1;
      if (rw) begin
        v = 64'h0;
        for (int unsigned k = 0; k < n; k++)
          v = v * 256 + 64'(ref_mem[(addr + k) % 256]);
        ref_out = v;
      end else begin
        for (int unsigned k = 0; k < n; k++)
          ref_mem[(addr + k) % 256] = 8'((din >> (8 * (n - 1 - k))) & 64'hFF);
      end
    end else begin
      ref_mov = 1'b0;
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic rw,
                      input logic [7:0] addr, input logic [1:0] ty,
                      input logic [63:0] din);
    reset = rst; Enable = en; ReadWrite = rw; Address = addr; Type = ty; DataIn = din;
    @(posedge clk);
    #1;
    model_step(rst, en, rw, addr, ty, din);
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".DataOut"}, DataOut, ref_out);
    check({tag, ".MOV"}, 64'(MOV), 64'(ref_mov));
  endtask

  task automatic check_mem(input string tag, input logic [7:0] a, input logic [7:0] exp);
    check(tag, 64'(dut.mem[a]), 64'(exp));
  endtask

  initial begin
    logic [63:0] held;
    reset = 1'b1; Enable = 1'b0; ReadWrite = 1'b1; Address = '0; Type = '0; DataIn = '0;
    ref_out = 64'h0; ref_mov = 1'b0;

    for (int unsigned i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      dut.mem[i] = ref_mem[i];
    end
    ref_mem[8'h10] = 8'h55;
    dut.mem[8'h10] = 8'h55;

    step(1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 64'h0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 64'h0);
    check("reset.DataOut", DataOut, 64'h0);
    check("reset.MOV", 64'(MOV), 64'h0);

    // Byte write/read
    step(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 64'hFFFF_FFFF_FFFF_FF9A);
    check("byte_wr.MOV", 64'(MOV), 64'h1);
    check("byte_wr.DataOut", DataOut, 64'h0);
    check_mem("byte_wr.mem00", 8'h00, 8'h9A);
    step(1'b0, 1'b1, 1'b1, 8'h00, 2'b00, 64'h0);
    check("byte_rd.DataOut", DataOut, 64'h9A);
    check("byte_rd.MOV", 64'(MOV), 64'h1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 64'h0);
    check("idle.MOV", 64'(MOV), 64'h0);
    check("idle.DataOut", DataOut, 64'h9A);

    // Halfword
    step(1'b0, 1'b1, 1'b0, 8'h04, 2'b01, 64'h1234);
    step(1'b0, 1'b1, 1'b1, 8'h04, 2'b00, 64'h0);
    check("half.byte04", DataOut, 64'h12);
    step(1'b0, 1'b1, 1'b1, 8'h05, 2'b00, 64'h0);
    check("half.byte05", DataOut, 64'h34);
    step(1'b0, 1'b1, 1'b1, 8'h04, 2'b01, 64'h0);
    check("half.rd", DataOut, 64'h1234);

    // Doubleword
    step(1'b0, 1'b1, 1'b0, 8'h08, 2'b11, 64'hCAFE_FEAF_BEBE_ABEE);
    step(1'b0, 1'b1, 1'b1, 8'h08, 2'b11, 64'h0);
    check("dword.rd", DataOut, 64'hCAFE_FEAF_BEBE_ABEE);
    step(1'b0, 1'b1, 1'b1, 8'h0C, 2'b10, 64'h0);
    check("dword.word0C", DataOut, 64'hBEBE_ABEE);

    // Wrap-around word
    step(1'b0, 1'b1, 1'b0, 8'hFE, 2'b10, 64'hDEAD_BEEF);
    check_mem("wrap.memFE", 8'hFE, 8'hDE);
    check_mem("wrap.memFF", 8'hFF, 8'hAD);
    check_mem("wrap.mem00", 8'h00, 8'hBE);
    check_mem("wrap.mem01", 8'h01, 8'hEF);
    step(1'b0, 1'b1, 1'b1, 8'hFE, 2'b10, 64'h0);
    check("wrap.rd", DataOut, 64'hDEAD_BEEF);

    // Enable low: DataIn wiggles, nothing changes
    held = DataOut;
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h20, 2'b11, {$urandom, $urandom});
      check("hold.MOV", 64'(MOV), 64'h0);
      check("hold.DataOut", DataOut, held);
    end
    check_mem("hold.mem20", 8'h20, ref_mem[8'h20]);

    // Reset beats a write
    step(1'b0, 1'b1, 1'b1, 8'h08, 2'b11, 64'h0);
    step(1'b1, 1'b1, 1'b0, 8'h10, 2'b00, 64'hAA);
    check("rst_wr.DataOut", DataOut, 64'h0);
    check("rst_wr.MOV", 64'(MOV), 64'h0);
    check_mem("rst_wr.mem10", 8'h10, 8'h55);
    step(1'b0, 1'b1, 1'b1, 8'h08, 2'b11, 64'h0);
    check("rst_persist.rd", DataOut, 64'hCAFE_FEAF_BEBE_ABEE);

    // Random traffic, reads biased toward recently written regions
    for (int unsigned i = 0; i < 400; i++) begin
      logic rst_r, en_r, rw_r;
      logic [7:0] a_r;
      rst_r = ($urandom_range(0, 29) == 0);
      en_r  = ($urandom_range(0, 4) != 0);
      rw_r  = 1'($urandom);
      a_r   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(248, 263)) : 8'($urandom);
      step(rst_r, en_r, rw_r, a_r, 2'($urandom), {$urandom, $urandom});
      check_outs("rand");
    end

    step(1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 64'h0);
    for (int unsigned i = 0; i < 256; i++)
      check_mem("final.mem", 8'(i), ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
